// File: rtl/rs232_pkg.sv
// Shared RS232 framing constants and baud-timing helpers for the receive and send paths.
package rs232_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic real unit_cycles(input real clock_freq, input real baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Centre of bit k in clock cycles after the start edge, rounded to nearest.
  function automatic int sample_pt(input real unit, input int k);
    return $rtoi(unit * (real'(k) + 0.5) + 0.5);
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Show-ahead synchronous byte FIFO with wrapping pointers and a fill count.
module rs232_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;

  logic [W-1:0] mem [DEPTH];
  cnt_t         wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == cnt_t'(DEPTH));
  assign rd_en = pop && !empty;
  // A pop frees the head slot this cycle, so a full FIFO still accepts the push.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rs232_recv_fifo.sv
// 8N1 receiver with 3-sample majority voting, byte FIFO, line-error flags and CTS hysteresis.
module rs232_recv_fifo
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  DEPTH      = 16,
  parameter int  STOP_LEVEL = 12,
  parameter int  GO_LEVEL   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       txd_pin,
  output logic       ctsn_pin,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       break_det
);
  localparam real UNIT    = unit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int  LAST_PT = sample_pt(UNIT, FRAME_BITS - 1) + 1;
  localparam int  TW      = $clog2(LAST_PT + 1);
  localparam int  CW      = $clog2(DEPTH) + 1;

  if (UNIT < 8.0 || DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0 ||
      GO_LEVEL >= STOP_LEVEL || STOP_LEVEL > DEPTH - 2) begin : g_bad_cfg
    $error("rs232_recv_fifo: illegal parameter combination");
  end

  // Decision times: one cycle after each bit centre, once all three votes are in.
  logic [FRAME_BITS-1:0][TW-1:0] samp_at;
  for (genvar k = 0; k < FRAME_BITS; k++) begin : g_pt
    assign samp_at[k] = TW'(sample_pt(UNIT, k) + 1);
  end

  logic [1:0]    sync;
  logic          txd, txd_q, txd_qq;
  rx_state_e     state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          at_pt, maj, stop_dec, push, pop, full, empty;
  logic [CW-1:0] fifo_count, count_nxt;

  assign txd      = sync[1];
  assign maj      = (txd & txd_q) | (txd & txd_qq) | (txd_q & txd_qq);
  assign at_pt    = (timer == samp_at[bit_idx]);
  assign stop_dec = (state == ST_STOP) && at_pt;
  assign valid    = !empty;
  assign pop      = valid && ready;
  assign push     = stop_dec && maj && (!full || pop);
  assign overrun  = stop_dec && maj && full && !pop;
  assign frame_err = stop_dec && !maj;
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      txd_q     <= 1'b1;
      txd_qq    <= 1'b1;
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      break_det <= 1'b0;
    end else begin
      sync   <= {sync[0], txd_pin};
      txd_q  <= txd;
      txd_qq <= txd_q;
      if (state inside {ST_START, ST_DATA, ST_STOP}) timer <= timer + 1'b1;
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (txd_q && !txd) begin
            state <= ST_START;
            timer <= TW'(1);
          end
        end
        ST_START: if (at_pt) begin
          if (maj) state <= ST_IDLE;
          else begin
            state   <= ST_DATA;
            bit_idx <= 4'd1;
          end
        end
        ST_DATA: if (at_pt) begin
          shreg   <= {maj, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 4'(DATA_BITS)) state <= ST_STOP;
        end
        // A good stop returns to IDLE mid stop bit so the next start edge is caught early.
        ST_STOP: if (at_pt) begin
          if (maj) state <= ST_IDLE;
          else begin
            state <= ST_WAIT_HIGH;
            if (shreg == 8'h00) break_det <= 1'b1;
          end
        end
        ST_WAIT_HIGH: if (txd) begin
          state     <= ST_IDLE;
          break_det <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               ctsn_pin <= 1'b1;
    else if (count_nxt >= CW'(STOP_LEVEL))   ctsn_pin <= 1'b1;
    else if (count_nxt <= CW'(GO_LEVEL))     ctsn_pin <= 1'b0;
  end

  rs232_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (data),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rs232_recv_fifo.sv
// Randomised bench for rs232_recv_fifo against a transaction-level receiver/FIFO model.
module tb_rs232_recv_fifo;
  localparam real CLK_F   = 1152000.0;
  localparam real BAUD    = 115200.0;
  localparam real UNIT    = CLK_F / BAUD;
  localparam int  BIT_CYC = $rtoi(UNIT + 0.5);
  localparam int  C9      = $rtoi(UNIT * 9.5 + 0.5);
  localparam int  DEPTH   = 16;
  localparam int  STOP_LV = 12;
  localparam int  GO_LV   = 8;
  localparam int  EV_GOOD = 1;
  localparam int  EV_FERR = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       txd_pin;
  logic       ready = 1'b0;
  logic       ctsn_pin, valid, frame_err, overrun, break_det;
  logic [7:0] data;

  int cyc = 0, pass_cnt = 0, total_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic rand_mode = 1'b0, ready_man = 1'b0;
  int         ev_kind [int];
  logic [7:0] ev_byte [int];
  logic [7:0] mq [$];
  logic [7:0] got_q [$];
  logic m_ctsn = 1'b1, m_wait = 1'b0, m_brk = 1'b0, pd1 = 1'b1, pd2 = 1'b1;

  rs232_recv_fifo #(
    .CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .DEPTH(DEPTH),
    .STOP_LEVEL(STOP_LV), .GO_LEVEL(GO_LV)
  ) dut (
    .clock(clock), .reset(reset), .txd_pin(txd_pin), .ctsn_pin(ctsn_pin),
    .data(data), .valid(valid), .ready(ready), .frame_err(frame_err),
    .overrun(overrun), .break_det(break_det)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #2;
    ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_man;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Stop decision lands 2 sync cycles plus one past the stop-bit centre after the pin falls.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit, input int goff);
    logic [9:0] fr;
    int d;
    fr = {stop, b, 1'b0};
    d = cyc + 2 + C9 + 1;
    ev_kind[d] = stop ? EV_GOOD : EV_FERR;
    ev_byte[d] = b;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < BIT_CYC; j++) begin
        txd_pin = fr[k] ^ (k == gbit && j == goff);
        step(1);
      end
    txd_pin = 1'b1;
  endtask

  always @(negedge clock) begin
    logic mtxd, full, pop;
    int k;
    logic [7:0] evb;
    mtxd = pd2; pd2 = pd1; pd1 = txd_pin;
    if (reset) begin
      chk("rst_valid", valid, 0);
      chk("rst_ctsn", ctsn_pin, 1);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_break", break_det, 0);
      mq.delete(); ev_kind.delete(); ev_byte.delete();
      m_ctsn = 1'b1; m_wait = 1'b0; m_brk = 1'b0; pd1 = 1'b1; pd2 = 1'b1;
    end else begin
      k   = ev_kind.exists(cyc) ? ev_kind[cyc] : 0;
      evb = ev_byte.exists(cyc) ? ev_byte[cyc] : 8'h00;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && ready;
      chk("valid", valid, mq.size() != 0);
      if (mq.size() != 0) chk("data", data, mq[0]);
      chk("ctsn", ctsn_pin, m_ctsn);
      chk("frame_err", frame_err, k == EV_FERR);
      chk("overrun", overrun, k == EV_GOOD && full && !pop);
      chk("break_det", break_det, m_brk);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (valid === 1'b1 && ready) got_q.push_back(data);
      if (pop) void'(mq.pop_front());
      if (k == EV_GOOD && (!full || pop)) mq.push_back(evb);
      if (mq.size() >= STOP_LV) m_ctsn = 1'b1;
      else if (mq.size() <= GO_LV) m_ctsn = 1'b0;
      if (k == EV_FERR) begin
        m_wait = 1'b1;
        if (evb == 8'h00) m_brk = 1'b1;
      end else if (m_wait && mtxd) begin
        m_wait = 1'b0;
        m_brk  = 1'b0;
      end
    end
  end

  initial begin
    int fe0, ov0;
    reset = 1'b1; txd_pin = 1'b1; ready_man = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("ctsn_release", ctsn_pin, 0);

    // Two clean bytes with the consumer always ready.
    ready_man = 1'b1; got_q.delete(); fe0 = fe_cnt;
    step(5);
    send_frame(8'h55, 1'b1, -1, 0); step(10);
    send_frame(8'hA3, 1'b1, -1, 0); step(20);
    chk("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_byte0", got_q[0], 8'h55);
      chk("t1_byte1", got_q[1], 8'hA3);
    end
    chk("t1_no_ferr", fe_cnt - fe0, 0);

    // Short low pulse, then a byte with a one-cycle glitch at a bit centre.
    got_q.delete();
    txd_pin = 1'b0; step(3); txd_pin = 1'b1; step(30);
    send_frame(8'h0F, 1'b1, 2, 5); step(20);
    chk("t2_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t2_byte", got_q[0], 8'h0F);

    // Framing error, then recovery.
    got_q.delete(); fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, -1, 0); step(20);
    send_frame(8'h3C, 1'b1, -1, 0); step(20);
    chk("t3_ferr_pulses", fe_cnt - fe0, 1);
    chk("t3_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t3_byte", got_q[0], 8'h3C);

    // Fill past the thresholds with the consumer stalled.
    ready_man = 1'b0; got_q.delete(); ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, -1, 0); step(5);
      chk("t4_ctsn_fill", ctsn_pin, (i >= 11) ? 1 : 0);
    end
    chk("t4_overrun_pulses", ov_cnt - ov0, 1);
    chk("t4_model_depth", mq.size(), 16);
    ready_man = 1'b1; step(7); ready_man = 1'b0; step(2);
    chk("t4_ctsn_at9", ctsn_pin, 1);
    ready_man = 1'b1; step(1); ready_man = 1'b0; step(2);
    chk("t4_ctsn_at8", ctsn_pin, 0);
    chk("t4_popped", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("t4_pop_order", got_q[i], i);
    ready_man = 1'b1; step(12);
    chk("t4_drained", got_q.size(), 16);
    if (got_q.size() == 16) chk("t4_last", got_q[15], 8'h0F);

    // Break: line low for 25 bit times.
    got_q.delete(); fe0 = fe_cnt;
    ev_kind[cyc + 2 + C9 + 1] = EV_FERR;
    ev_byte[cyc + 2 + C9 + 1] = 8'h00;
    txd_pin = 1'b0; step(25 * BIT_CYC);
    chk("t5_break_held", break_det, 1);
    chk("t5_ferr_pulses", fe_cnt - fe0, 1);
    txd_pin = 1'b1; step(5);
    chk("t5_break_clear", break_det, 0);
    chk("t5_no_bytes", got_q.size(), 0);

    // Reset in the middle of data bit 4.
    got_q.delete();
    for (int k = 0; k < 4; k++) begin
      txd_pin = (k == 0) ? 1'b0 : k[0];
      step(BIT_CYC);
    end
    txd_pin = 1'b0; step(5);
    reset = 1'b1; txd_pin = 1'b1; #1;
    chk("t6_rst_ctsn", ctsn_pin, 1);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_break", break_det, 0);
    step(3); reset = 1'b0; step(20);
    send_frame(8'h7E, 1'b1, -1, 0); step(20);
    chk("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t6_byte", got_q[0], 8'h7E);

    // Random bytes, stop bits, glitches, gaps and consumer stalls.
    rand_mode = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      logic st;
      int gb;
      b  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      send_frame(b, st, gb, int'($urandom_range(0, BIT_CYC - 1)));
      step(int'($urandom_range(2, 30)));
    end
    rand_mode = 1'b0; ready_man = 1'b1;
    step(40);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rs232_recv_fifo.md
# rs232_recv_fifo

Flow-controlled RS232 receiver with a built-in byte FIFO, majority-vote bit sampling and line-error reporting. It deserialises 8N1 frames arriving on `txd_pin` from the USB-UART bridge and drives the bridge's `ctsn_pin` with hysteresis, so the remote transmitter stops early enough that bytes already in flight are never lost. Received bytes are offered to fabric logic on a valid/ready stream.

## Interface
- `CLOCK_FREQ`, real, 133000000: clock frequency in Hz.
- `BAUD_RATE`, real, 115200: line rate in baud. `CLOCK_FREQ/BAUD_RATE >= 8` is required, and an elaboration check enforces it.
- `DEPTH`, integer, 16: FIFO depth in bytes. Must be a power of two and at least 8.
- `STOP_LEVEL`, integer, 12: fill count at or above which `ctsn_pin` goes high.
- `GO_LEVEL`, integer, 8: fill count at or below which `ctsn_pin` goes low. `GO_LEVEL < STOP_LEVEL <= DEPTH-2`.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `txd_pin` in 1: serial data from the bridge; asynchronous to `clock`.
- `ctsn_pin` out 1: active-low clear-to-send toward the bridge; 1 means stop sending.
- `data` out 8: head-of-FIFO byte.
- `valid` out 1: FIFO not empty.
- `ready` in 1: consumer accepts `data` when `valid && ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `break_det` out 1: level; line held low for a whole frame.

## Operation
- `txd_pin` passes through a 2-FF synchroniser (reset value 1) to give `txd`. All logic below uses `txd`.
- UNIT = CLOCK_FREQ/BAUD_RATE. Bit k (0 = start, 1..8 = data LSB first, 9 = stop) has centre C_k = round(UNIT*(k+0.5)) timer cycles after the falling edge.
- The bit value is the majority of `txd` at C_k-1, C_k and C_k+1.
- States:
  - IDLE: the timer is held at 0. A 1→0 transition on `txd` enters START.
  - START: the majority at C_0 decides. A value of 1 is a false start and returns to IDLE with no flag. A value of 0 enters DATA.
  - DATA: the 8 bits are shifted in, LSB first.
  - STOP: decided at C_9+1.
    - Stop bit = 1: the byte is pushed into the FIFO, or, if the FIFO is full, it is dropped and `overrun` pulses. The next state is IDLE, so resynchronisation starts mid stop bit.
    - Stop bit = 0: `frame_err` pulses and the byte is discarded. If all data bits were 0 as well, `break_det` is set. The next state is WAIT_HIGH.
  - WAIT_HIGH: stays until `txd` = 1, then goes to IDLE. `break_det` clears on the same edge that leaves WAIT_HIGH.
- FIFO: a synchronous, show-ahead FIFO holding DEPTH bytes, with `$clog2(DEPTH)+1`-bit wrapping pointers.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full, where the push succeeds because a pop also occurs.
  - No pop happens when the FIFO is empty.
- Flow control:
  - `ctsn_pin` is registered from the post-operation count.
  - It sets when the count is at least STOP_LEVEL and clears when the count is at most GO_LEVEL; otherwise it holds its value.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied. A following frame is received correctly.

## Timing
- Reset values:
  - `ctsn_pin` = 1; it is released to 0 on the first clock after reset deasserts, since the FIFO is empty.
  - `valid`, `frame_err`, `overrun` and `break_det` = 0.
  - `data` is don't-care whenever `valid` = 0.
- Latency: `valid` rises 1 cycle after the push cycle, and the push cycle is C_9+1 after the synchronised falling edge. From `txd_pin` that is 2 further cycles.
- After a pop, `data` and `valid` update on the next clock edge.
- `ctsn_pin` changes 1 cycle after the push or pop that crosses the threshold.
- `frame_err` and `overrun` fire in the same cycle as the stop decision.
- A noise pulse of 1 cycle at any sample point has no effect.
- A low pulse shorter than C_0-1 cycles is rejected.

## Structure
- Shared package `rs232_pkg`:
  - a UNIT helper and a sample-point rounding function C(k) for use by `rs232_recv_fifo` and future senders;
  - frame-field constants DATA_BITS = 8 and FRAME_BITS = 10.
- Sub-module `rs232_fifo` (the DEPTH-parameterised show-ahead sync FIFO with a count output) is instantiated once. It is kept reusable for the send path.

## Test plan
Use CLOCK_FREQ = 1152000 and BAUD_RATE = 115200, so UNIT = 10. Use DEPTH = 16, STOP_LEVEL = 12 and GO_LEVEL = 8 unless noted.
- Send 0x55 and then 0xA3, with `ready` = 1 → `data` shows 0x55 and then 0xA3, each with one `valid`/`ready` beat. No error pulses. `ctsn_pin` stays 0.
- Drive `txd_pin` low for 3 cycles, and separately a single-cycle glitch inside a data bit of 0x0F → no byte from the first. The second yields 0x0F unchanged.
- Send 0xA3 with the stop bit low → `frame_err` pulses once, `break_det` stays 0, `valid` stays 0. The following 0x3C frame is received correctly.
- Keep `ready` = 0 and send 17 bytes 0x00..0x10:
  - `ctsn_pin` goes to 1 one cycle after the 12th push;
  - the 17th byte produces an `overrun` pulse and is absent;
  - popping 8 bytes drops `ctsn_pin` to 0 after the count reaches 8;
  - the pops return 0x00..0x07 in order.
- Hold the line low for 25 bit times, then release it → one `frame_err` pulse and `break_det` = 1 until `txd` returns high. No bytes are pushed.
- Assert `reset` in the middle of bit 4 of a frame → all outputs take their reset values immediately. The next 0x7E frame is received correctly after release.
